// File: rtl/soduku_board_serializer.sv
// Serialises a snapshot of the packed 9x9 solver board one cell per valid/ready beat,
// row-major, as BCD bytes or ASCII digits with a line feed closing each row.
module soduku_board_serializer #(
  parameter int GRID_SIZE  = 9,
  parameter int ASCII_MODE = 0
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic [323:0] board_in,
  input  logic         start_in,
  output logic         busy_out,
  output logic [7:0]   data_out,
  output logic         valid_out,
  input  logic         ready_in,
  output logic [3:0]   row_out,
  output logic [3:0]   col_out,
  output logic         last_out,
  output logic         done_out,
  output logic [6:0]   zero_count_out,
  output logic         bad_digit_out
);

  generate
    if (GRID_SIZE != 9) begin : g_bad_grid_size
      $error("soduku_board_serializer: only GRID_SIZE = 9 is supported");
    end
  endgenerate

  localparam bit          ASCII_EN = (ASCII_MODE != 0);
  localparam logic [3:0]  LAST_IDX = 4'd8;
  localparam logic [3:0]  EOL_COL  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_EOL  = 2'd2
  } state_t;

  // Handshake: a beat transfers on a rising edge where valid_out and ready_in are both
  // high; while valid_out is high it only falls after a transfer (or reset), and the
  // beat payload and indices hold steady until that transfer.
  state_t         state_q, state_d;
  logic [323:0]   snap_q, snap_d;
  logic [3:0]     row_q, row_d;
  logic [3:0]     col_q, col_d;
  logic [6:0]     zero_q, zero_d;
  logic           bad_q, bad_d;
  logic           done_q, done_d;

  logic [3:0]     cell_nib;
  logic           cell_bad;
  logic [7:0]     cell_byte;

  // The snapshot shifts left one nibble per transferred cell, so the current cell is
  // always the top nibble and no row/column address decode is needed.
  assign cell_nib = snap_q[323:320];
  assign cell_bad = (cell_nib > 4'd9);

  always_comb begin
    cell_byte = {4'h0, cell_nib};
    if (cell_bad) begin
      cell_byte = 8'h3F;
    end else if (ASCII_EN) begin
      cell_byte = {4'h3, cell_nib};
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    row_d   = row_q;
    col_d   = col_q;
    zero_d  = zero_q;
    bad_d   = bad_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          snap_d  = board_in;
          row_d   = 4'd0;
          col_d   = 4'd0;
          zero_d  = 7'd0;
          bad_d   = 1'b0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ready_in) begin
          snap_d = {snap_q[319:0], 4'h0};
          if (cell_nib == 4'd0) begin
            zero_d = zero_q + 7'd1;
          end
          if (cell_bad) begin
            bad_d = 1'b1;
          end
          if (col_q < LAST_IDX) begin
            col_d = col_q + 4'd1;
          end else if (ASCII_EN) begin
            col_d   = EOL_COL;
            state_d = ST_EOL;
          end else if (row_q < LAST_IDX) begin
            row_d = row_q + 4'd1;
            col_d = 4'd0;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_EOL: begin
        if (ready_in) begin
          if (row_q < LAST_IDX) begin
            row_d   = row_q + 4'd1;
            col_d   = 4'd0;
            state_d = ST_SEND;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      row_q   <= 4'd0;
      col_q   <= 4'd0;
      zero_q  <= 7'd0;
      bad_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      zero_q  <= zero_d;
      bad_q   <= bad_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    valid_out = (state_q != ST_IDLE);
    busy_out  = (state_q != ST_IDLE);
    data_out  = 8'h00;
    last_out  = 1'b0;
    case (state_q)
      ST_SEND: begin
        data_out = cell_byte;
        last_out = !ASCII_EN && (row_q == LAST_IDX) && (col_q == LAST_IDX);
      end
      ST_EOL: begin
        data_out = 8'h0A;
        last_out = (row_q == LAST_IDX);
      end
      default: begin
        data_out = 8'h00;
      end
    endcase
    row_out        = row_q;
    col_out        = col_q;
    done_out       = done_q;
    zero_count_out = zero_q;
    bad_digit_out  = bad_q;
  end

endmodule

// File: tb/tb_soduku_board_serializer.sv
// Bench for soduku_board_serializer: a BCD and an ASCII instance share stimulus and are
// checked every cycle against a beat-list model built from the board snapshot.
module tb_soduku_board_serializer;

  localparam int W = 22;  // {data[21:14], row[13:10], col[9:6], last[5], is_cell[4], nib[3:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         start;
  logic         ready;
  logic [323:0] board;

  logic         busy_o  [2];
  logic [7:0]   data_o  [2];
  logic         valid_o [2];
  logic [3:0]   row_o   [2];
  logic [3:0]   col_o   [2];
  logic         last_o  [2];
  logic         done_o  [2];
  logic [6:0]   zero_o  [2];
  logic         bad_o   [2];

  soduku_board_serializer #(.GRID_SIZE(9), .ASCII_MODE(0)) dut_bcd (
    .clk_in(clk), .reset_in(reset_n), .board_in(board), .start_in(start),
    .busy_out(busy_o[0]), .data_out(data_o[0]), .valid_out(valid_o[0]), .ready_in(ready),
    .row_out(row_o[0]), .col_out(col_o[0]), .last_out(last_o[0]), .done_out(done_o[0]),
    .zero_count_out(zero_o[0]), .bad_digit_out(bad_o[0])
  );

  soduku_board_serializer #(.GRID_SIZE(9), .ASCII_MODE(1)) dut_asc (
    .clk_in(clk), .reset_in(reset_n), .board_in(board), .start_in(start),
    .busy_out(busy_o[1]), .data_out(data_o[1]), .valid_out(valid_o[1]), .ready_in(ready),
    .row_out(row_o[1]), .col_out(col_o[1]), .last_out(last_o[1]), .done_out(done_o[1]),
    .zero_count_out(zero_o[1]), .bad_digit_out(bad_o[1])
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q [2][$];
  bit           active   [2];
  bit           done_exp [2];
  int           exp_zero [2];
  bit           exp_bad  [2];
  bit           just_reset;

  logic [7:0]   got_data [2][90];
  logic [3:0]   got_col  [2][90];
  logic         got_last [2][90];
  int           got_n    [2];
  int           done_seen[2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%0h expected=%0h", name, m, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [3:0] n, input bit asc);
    if (n > 4'd9) return 8'h3F;
    if (asc) return 8'h30 + {4'h0, n};
    return {4'h0, n};
  endfunction

  function automatic logic [3:0] get_cell(input logic [323:0] b, input int r, input int c);
    return b[323 - 36*r - 4*c -: 4];
  endfunction

  function automatic logic [323:0] set_cell(input logic [323:0] b, input int r, input int c,
                                            input logic [3:0] n);
    logic [323:0] t;
    t = b;
    t[323 - 36*r - 4*c -: 4] = n;
    return t;
  endfunction

  task automatic load_model(input int m, input logic [323:0] b);
    logic [3:0] n;
    exp_q[m].delete();
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 9; c++) begin
        n = get_cell(b, r, c);
        exp_q[m].push_back({model_byte(n, m == 1), 4'(r), 4'(c),
                            (m == 0) && (r == 8) && (c == 8), 1'b1, n});
      end
      if (m == 1) exp_q[m].push_back({8'h0A, 4'(r), 4'd9, r == 8, 1'b0, 4'h0});
    end
    active[m]    = 1'b1;
    exp_zero[m]  = 0;
    exp_bad[m]   = 1'b0;
    got_n[m]     = 0;
    done_seen[m] = 0;
  endtask

  // ---------------- compare process ----------------
  // Checks at the falling edge describe the state after the previous rising edge; the
  // model is then advanced using the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    logic [W-1:0] f;
    for (int m = 0; m < 2; m++) begin
      chk("valid", m, valid_o[m], active[m]);
      chk("busy", m, busy_o[m], active[m]);
      chk("done", m, done_o[m], done_exp[m]);
      chk("zero_count", m, zero_o[m], exp_zero[m]);
      chk("bad_digit", m, bad_o[m], exp_bad[m]);
      if (done_o[m] === 1'b1) done_seen[m]++;
      if (active[m] && exp_q[m].size() > 0) begin
        f = exp_q[m][0];
        chk("data", m, data_o[m], f[21:14]);
        chk("row", m, row_o[m], f[13:10]);
        chk("col", m, col_o[m], f[9:6]);
        chk("last", m, last_o[m], f[5]);
      end
      if (just_reset) begin
        chk("reset_data", m, data_o[m], 0);
        chk("reset_row", m, row_o[m], 0);
        chk("reset_col", m, col_o[m], 0);
        chk("reset_last", m, last_o[m], 0);
      end
    end
    if (!reset_n) begin
      just_reset = 1'b1;
      for (int m = 0; m < 2; m++) begin
        exp_q[m].delete();
        active[m]   = 1'b0;
        done_exp[m] = 1'b0;
        exp_zero[m] = 0;
        exp_bad[m]  = 1'b0;
      end
    end else begin
      just_reset = 1'b0;
      for (int m = 0; m < 2; m++) begin
        done_exp[m] = 1'b0;
        if (active[m]) begin
          if (ready && exp_q[m].size() > 0) begin
            f = exp_q[m].pop_front();
            if (got_n[m] < 90) begin
              got_data[m][got_n[m]] = data_o[m];
              got_col[m][got_n[m]]  = col_o[m];
              got_last[m][got_n[m]] = last_o[m];
            end
            got_n[m]++;
            if (f[4] && f[3:0] == 4'd0) exp_zero[m]++;
            if (f[4] && f[3:0] > 4'd9) exp_bad[m] = 1'b1;
            if (f[5]) begin
              active[m]   = 1'b0;
              done_exp[m] = 1'b1;
            end
          end
        end else if (start) begin
          load_model(m, board);
        end
      end
    end
  end

  // ---------------- driver ----------------
  int ready_mode = 0;  // 0: always high, 1: pattern 1,0,0,1, 2: random
  int pc = 0;
  always @(posedge clk) begin
    #1;
    pc++;
    case (ready_mode)
      1:       ready = (pc % 4 == 0) || (pc % 4 == 3);
      2:       ready = ($urandom_range(0, 3) != 0);
      default: ready = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [323:0] b);
    board = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit timed_out;
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!active[0] && !active[1] && busy_o[0] === 1'b0 && busy_o[1] === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
    chk("idle_timeout", 0, timed_out, 0);
    tick();
    tick();
  endtask

  task automatic wait_beats(input int n);
    bit timed_out;
    timed_out = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (got_n[0] >= n) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
    chk("beat_timeout", 0, timed_out, 0);
  endtask

  function automatic logic [323:0] solved_board();
    logic [323:0] b;
    logic [3:0] r0 [9] = '{4'd2, 4'd5, 4'd4, 4'd8, 4'd1, 4'd3, 4'd6, 4'd9, 4'd7};
    logic [3:0] r8 [9] = '{4'd9, 4'd4, 4'd6, 4'd3, 4'd5, 4'd7, 4'd2, 4'd1, 4'd8};
    b = '0;
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 9; c++) begin
        if (r == 0)      b = set_cell(b, r, c, r0[c]);
        else if (r == 8) b = set_cell(b, r, c, r8[c]);
        else             b = set_cell(b, r, c, 4'(((r + c) % 9) + 1));
      end
    end
    return b;
  endfunction

  function automatic logic [323:0] random_board(input bit allow_bad);
    logic [323:0] b;
    for (int i = 0; i < 81; i++) begin
      if (allow_bad && $urandom_range(0, 9) == 0) b[4*i +: 4] = 4'($urandom_range(10, 15));
      else b[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return b;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [323:0] b;
    reset_n = 1'b0;
    start   = 1'b0;
    ready   = 1'b1;
    board   = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    chk("rst_valid_lit", 0, valid_o[0], 0);
    chk("rst_zero_lit", 1, zero_o[1], 0);
    tick();

    // Solved board, ready held high, both output formats.
    b = solved_board();
    pulse_start(b);
    wait_idle();
    chk("bcd_beats", 0, got_n[0], 81);
    chk("bcd_beat0", 0, got_data[0][0], 8'h02);
    chk("bcd_beat80", 0, got_data[0][80], 8'h08);
    chk("bcd_beat80_last", 0, got_last[0][80], 1);
    chk("bcd_done_count", 0, done_seen[0], 1);
    chk("bcd_zero_lit", 0, zero_o[0], 0);
    chk("bcd_bad_lit", 0, bad_o[0], 0);
    chk("asc_beats", 1, got_n[1], 90);
    chk("asc_beat0", 1, got_data[1][0], 8'h32);
    chk("asc_beat9", 1, got_data[1][9], 8'h0A);
    chk("asc_beat9_col", 1, got_col[1][9], 9);
    chk("asc_beat89", 1, got_data[1][89], 8'h0A);
    chk("asc_beat89_last", 1, got_last[1][89], 1);
    chk("asc_done_count", 1, done_seen[1], 1);

    // Backpressure 1,0,0,1.
    ready_mode = 1;
    pulse_start(random_board(1'b0));
    wait_idle();
    chk("bp_bcd_beats", 0, got_n[0], 81);
    chk("bp_asc_beats", 1, got_n[1], 90);

    // Zero cells: row 8 = 0..0,8 and (5,5) = 0.
    ready_mode = 2;
    b = solved_board();
    for (int c = 0; c < 8; c++) b = set_cell(b, 8, c, 4'd0);
    b = set_cell(b, 5, 5, 4'd0);
    pulse_start(b);
    wait_idle();
    chk("zero9_bcd", 0, zero_o[0], 9);
    chk("zero9_asc", 1, zero_o[1], 9);
    chk("zero_bcd_55", 0, got_data[0][50], 8'h00);
    chk("zero_bcd_80", 0, got_data[0][72], 8'h00);
    chk("zero_asc_55", 1, got_data[1][55], 8'h30);
    chk("zero_asc_80", 1, got_data[1][80], 8'h30);

    // Illegal nibble at (3,4), then cleared by the next start.
    ready_mode = 0;
    b = set_cell(solved_board(), 3, 4, 4'hF);
    pulse_start(b);
    wait_idle();
    chk("bad_bcd_beat", 0, got_data[0][31], 8'h3F);
    chk("bad_asc_beat", 1, got_data[1][34], 8'h3F);
    chk("bad_bcd_sticky", 0, bad_o[0], 1);
    chk("bad_asc_sticky", 1, bad_o[1], 1);
    pulse_start(solved_board());
    chk("bad_cleared", 0, bad_o[0], 0);
    wait_idle();

    // Isolation: new board and extra start at beat 10; reset at beat 40.
    b = random_board(1'b1);
    pulse_start(b);
    wait_beats(10);
    board = ~b;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_beats(40);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("abort_valid", 0, valid_o[0], 0);
    chk("abort_busy", 1, busy_o[1], 0);
    chk("abort_zero", 0, zero_o[0], 0);
    repeat (3) tick();
    chk("abort_no_done", 0, done_seen[0], 0);
    chk("abort_no_done", 1, done_seen[1], 0);

    // Random boards and ready, with start sometimes held across completion.
    ready_mode = 2;
    for (int k = 0; k < 4; k++) begin
      board = random_board(1'b1);
      start = 1'b1;
      repeat ($urandom_range(1, 150)) tick();
      start = 1'b0;
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
